iic_master_16b: RTL

IIC_MASTER_16B -- requirements
Module: iic_master_16b

---
 rtl/iic_pkg.sv | 32 +++
 rtl/iic_clk_div.sv | 36 +++
 rtl/iic_master_16b.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the 16-bit-register IIC master:
// one-hot state encoding, R/W bit values and state helpers.
package iic_pkg;

   typedef enum logic [9:0] {
      IDLE    = 10'b00_0000_0001,
      START   = 10'b00_0000_0010,
      DEV_W   = 10'b00_0000_0100,
      REG_H   = 10'b00_0000_1000,
      REG_L   = 10'b00_0001_0000,
      WR_DATA = 10'b00_0010_0000,
      RESTART = 10'b00_0100_0000,
      DEV_R   = 10'b00_1000_0000,
      RD_DATA = 10'b01_0000_0000,
      STOP    = 10'b10_0000_0000
   } iic_state_e;

   localparam logic IIC_WR_BIT = 1'b0;
   localparam logic IIC_RD_BIT = 1'b1;

   // States that move nine SCL bits (8 data + ACK slot)
   function automatic logic is_byte_state(input iic_state_e s);
      return (s == DEV_W) || (s == REG_H) || (s == REG_L) ||
             (s == WR_DATA) || (s == DEV_R) || (s == RD_DATA);
   endfunction

   // Byte states where the master drives the data bits
   function automatic logic is_tx_state(input iic_state_e s);
      return is_byte_state(s) && (s != RD_DATA);
   endfunction

endpackage

// File: rtl/iic_clk_div.sv
// Quarter-SCL tick generator: one-clock tick every
// CLK_FREQ/(4*IIC_FREQ) clocks while enabled.
module iic_clk_div #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int IIC_FREQ = 100_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int DIV = CLK_FREQ / (4 * IIC_FREQ);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Count while enabled; restart from zero whenever idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (!en) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == LAST) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + 1'b1;
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/iic_master_16b.sv
// IIC master: write/read of one byte at a 16-bit register address.
// Optional IIC_ACK_CHECK_EN adds ack_err and aborts on NACK.
module iic_master_16b
   import iic_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int IIC_FREQ = 100_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  device_id,
   input  logic        iic_trig,
   input  logic        w_r,
   input  logic [15:0] addr,
   input  logic [7:0]  data_in,
   output logic        busy,
   output logic [7:0]  data_out,
   output logic        byte_over,
   output logic        scl,
`ifdef IIC_ACK_CHECK_EN
   output logic        ack_err,
`endif
   inout  wire         sda
);

   iic_state_e state_q, state_d;

   logic       tick;
   logic [1:0] qtr;
   logic [3:0] bit_cnt;
   logic [7:0] tx_sh;
   logic [7:0] rx_sh;
   logic [7:0] load_byte;
   logic       sda_q;
   logic       end_bit;
   logic       end_byte;
   logic       nack;
   logic       bo_d;

   logic [6:0]  dev_id;
   logic        wr;
   logic [15:0] reg_addr;
   logic [7:0]  wdata;

   logic unused_id0;
   assign unused_id0 = device_id[0];

   assign sda      = sda_q ? 1'bz : 1'b0;
   assign end_bit  = tick && (qtr == 2'd3);
   assign end_byte = end_bit && (bit_cnt == 4'd8);

`ifdef IIC_ACK_CHECK_EN
   logic ack_bit;
   assign nack = ack_bit;
`else
   assign nack = 1'b0;
`endif

   iic_clk_div #(
      .CLK_FREQ (CLK_FREQ),
      .IIC_FREQ (IIC_FREQ)
   ) u_div (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q != IDLE),
      .tick (tick)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state, byte_over request and byte to load on entry
   always_comb begin
      state_d   = state_q;
      bo_d      = 1'b0;
      load_byte = 8'h00;
      case (state_q)
         IDLE:    if (iic_trig) state_d = START;
         START:   if (end_bit) state_d = DEV_W;
         DEV_W:   if (end_byte) state_d = nack ? STOP : REG_H;
         REG_H:   if (end_byte) state_d = nack ? STOP : REG_L;
         REG_L: begin
            if (end_byte) begin
               if (nack)    state_d = STOP;
               else if (wr) state_d = WR_DATA;
               else         state_d = RESTART;
            end
         end
         WR_DATA: begin
            if (end_byte) begin
               state_d = STOP;
               bo_d    = !nack;
            end
         end
         RESTART: if (end_bit) state_d = DEV_R;
         DEV_R:   if (end_byte) state_d = nack ? STOP : RD_DATA;
         RD_DATA: begin
            if (end_byte) begin
               state_d = STOP;
               bo_d    = 1'b1;
            end
         end
         STOP:    if (end_bit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      case (state_d)
         DEV_W:   load_byte = {dev_id, IIC_WR_BIT};
         REG_H:   load_byte = reg_addr[15:8];
         REG_L:   load_byte = reg_addr[7:0];
         WR_DATA: load_byte = wdata;
         DEV_R:   load_byte = {dev_id, IIC_RD_BIT};
         default: load_byte = 8'h00;
      endcase
   end

   // Bus sequencing: SCL/SDA edges, shifting and bit counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl     <= 1'b1;
         sda_q   <= 1'b1;
         qtr     <= 2'd0;
         bit_cnt <= 4'd0;
         tx_sh   <= 8'h00;
         rx_sh   <= 8'h00;
`ifdef IIC_ACK_CHECK_EN
         ack_bit <= 1'b0;
`endif
      end else begin
         if (tick) begin
            case (state_q)
               START: begin
                  if (qtr == 2'd2) sda_q <= 1'b0;
                  if (qtr == 2'd3) scl   <= 1'b0;
               end
               RESTART: begin
                  case (qtr)
                     2'd0:    sda_q <= 1'b1;
                     2'd1:    scl   <= 1'b1;
                     2'd2:    sda_q <= 1'b0;
                     default: scl   <= 1'b0;
                  endcase
               end
               STOP: begin
                  case (qtr)
                     2'd0:    sda_q <= 1'b0;
                     2'd1:    scl   <= 1'b1;
                     2'd2:    sda_q <= 1'b1;
                     default: ;
                  endcase
               end
               default: begin
                  if (is_byte_state(state_q)) begin
                     case (qtr)
                        2'd0: begin
                           scl <= 1'b0;
                           if (bit_cnt == 4'd8 ||
                               !is_tx_state(state_q))
                              sda_q <= 1'b1;
                           else
                              sda_q <= tx_sh[7];
                        end
                        2'd1: scl <= 1'b1;
                        2'd2: begin
                           if (bit_cnt != 4'd8 &&
                               state_q == RD_DATA)
                              rx_sh <= {rx_sh[6:0], sda};
`ifdef IIC_ACK_CHECK_EN
                           if (bit_cnt == 4'd8)
                              ack_bit <= sda;
`endif
                        end
                        default: begin
                           scl   <= 1'b0;
                           tx_sh <= {tx_sh[6:0], 1'b0};
                        end
                     endcase
                  end
               end
            endcase
         end
         if (state_d != state_q) begin
            qtr     <= 2'd0;
            bit_cnt <= 4'd0;
            tx_sh   <= load_byte;
         end else if (tick) begin
            qtr <= qtr + 2'd1;
            if (qtr == 2'd3) bit_cnt <= bit_cnt + 4'd1;
         end
      end
   end

   // Request latch, busy, byte_over, read data and ack error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         byte_over <= 1'b0;
         data_out  <= 8'h00;
         dev_id    <= 7'h00;
         wr        <= 1'b0;
         reg_addr  <= 16'h0000;
         wdata     <= 8'h00;
`ifdef IIC_ACK_CHECK_EN
         ack_err   <= 1'b0;
`endif
      end else begin
         busy      <= (state_d != IDLE);
         byte_over <= bo_d;
         if (state_q == IDLE && iic_trig) begin
            dev_id   <= device_id[7:1];
            wr       <= w_r;
            reg_addr <= addr;
            wdata    <= data_in;
`ifdef IIC_ACK_CHECK_EN
            ack_err  <= 1'b0;
`endif
         end
         if (end_byte && state_q == RD_DATA)
            data_out <= rx_sh;
`ifdef IIC_ACK_CHECK_EN
         if (end_byte && is_tx_state(state_q) && ack_bit)
            ack_err <= 1'b1;
`endif
      end
   end

endmodule
